memory_bus_arbiter: RTL
=======================

MEMORY_BUS_ARBITER -- requirements
Module: memory_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: bus cycles without ack before a transaction is aborted with error.
REQ-002 Parameter STORE_STARVE_LIMIT, default 4: consecutive load grants tolerated while a store is pending.
REQ-003 clk_i input 1: single clock; all state on rising edge.
REQ-004 rst_i input 1: reset, asynchronous, active-high.
REQ-005 flush_i input 1: pipeline flush; kills the pending load result.
REQ-006 load_request_i input 1: load unit requests a bus read.
REQ-007 load_address_i input 32: word-aligned read address.
REQ-008 load_data_o output 32: read data, valid only with load_done_o.
REQ-009 load_done_o output 1: one-cycle pulse, load complete.
REQ-010 load_error_o output 1: one-cycle pulse, load aborted on bus error or timeout.
REQ-011 store_request_i input 1: store unit requests a bus write.
REQ-012 store_address_i input 32: write address.
REQ-013 store_data_i input 32: write data, lane-aligned.
REQ-014 store_width_i input 2: 00 byte, 01 half, 10 word; 11 reserved.
REQ-015 store_done_o output 1: one-cycle pulse, store accepted by bus.
REQ-016 store_error_o output 1: one-cycle pulse, store aborted.
REQ-017 bus_request_o output 1: transaction active, held until ack/error/timeout.
REQ-018 bus_write_o output 1: 1 write, 0 read.
REQ-019 bus_address_o output 32, bus_wdata_o output 32, bus_byte_enable_o output 4: registered transaction fields.
REQ-020 bus_rdata_i input 32, bus_ack_i input 1, bus_error_i input 1: bus response.

Function
REQ-021 FSM states IDLE, LOAD_WAIT, STORE_WAIT; one transaction outstanding at most.
REQ-022 IDLE, load only pending -> LOAD_WAIT next cycle; store only -> STORE_WAIT.
REQ-023 IDLE, both pending: load wins unless starvation counter == STORE_STARVE_LIMIT, then store wins.
REQ-024 Starvation counter: increments on load grant while store_request_i high, clears on any store grant or when store_request_i low; saturates at limit.
REQ-025 On grant, address/data/byte-enable/write captured into registers; requester inputs ignored until done/error.
REQ-026 Byte enables from store_width_i and store_address_i[1:0]: byte 0001<<a[1:0]; half 0011<<(a[1]*2); word 1111; loads 1111; width 11 treated as word.
REQ-027 bus_request_o high for every cycle in LOAD_WAIT/STORE_WAIT, low in IDLE.
REQ-028 bus_ack_i in LOAD_WAIT: load_data_o <= bus_rdata_i, load_done_o pulses next cycle, FSM -> IDLE.
REQ-029 bus_ack_i in STORE_WAIT: store_done_o pulses next cycle, FSM -> IDLE.
REQ-030 bus_error_i (priority over ack if both high) -> matching *_error_o pulse next cycle, FSM -> IDLE.
REQ-031 Timeout counter (8+ bits per TIMEOUT_CYCLES) clears on grant, increments each WAIT cycle; reaching TIMEOUT_CYCLES = bus_error_i behaviour.
REQ-032 Minimum latency request->done: 3 cycles (grant, ack, pulse); back-to-back grant allowed the cycle after returning to IDLE.
REQ-033 flush_i during LOAD_WAIT: transaction completes on bus (no abort), load_done_o/load_error_o suppressed; flush in STORE_WAIT has no effect.
REQ-034 flush_i in IDLE same cycle as load_request_i: load not granted.
REQ-035 Ack in IDLE ignored; no outputs pulse.

Reset
REQ-036 rst_i asserted: FSM IDLE, all outputs 0, counters 0, immediately (asynchronous), including mid-transaction.
REQ-037 First grant possible on first rising edge after rst_i deasserts.

Verification
REQ-038 Load 0x1000, ack after 2 wait cycles with rdata 0xDEADBEEF -> load_done_o single pulse, load_data_o 0xDEADBEEF, bus_write_o 0.
REQ-039 Store byte addr 0x2003 data 0xAA000000 -> bus_byte_enable_o 1000, store_done_o pulse after ack.
REQ-040 Load and store held continuously, acks immediate -> 4 loads granted, then store, sequence repeats.
REQ-041 Load with no ack -> load_error_o pulses exactly TIMEOUT_CYCLES cycles after grant, FSM IDLE.
REQ-042 flush_i in LOAD_WAIT, then ack -> no load_done_o; following store granted normally.
REQ-043 rst_i asserted in STORE_WAIT -> bus_request_o 0 same cycle, no store_done_o after release.

Source files
------------

// File: rtl/memory_bus_arbiter_if.sv
// Bus-side signals between the arbiter (master) and the memory bus (slave).
// Handshake: bus_request_o is held with stable fields until the slave answers with bus_ack_i or bus_error_i.
interface memory_bus_arbiter_if;
    logic        bus_request_o;
    logic        bus_write_o;
    logic [31:0] bus_address_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_byte_enable_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic        bus_error_i;

    modport master (
        output bus_request_o, bus_write_o, bus_address_o, bus_wdata_o, bus_byte_enable_o,
        input  bus_rdata_i, bus_ack_i, bus_error_i
    );

    modport slave (
        input  bus_request_o, bus_write_o, bus_address_o, bus_wdata_o, bus_byte_enable_o,
        output bus_rdata_i, bus_ack_i, bus_error_i
    );
endinterface

// File: rtl/memory_bus_arbiter.sv
// Arbitrates one load unit and one store unit onto a single-outstanding memory bus,
// with store anti-starvation, bus timeout and load flush.
module memory_bus_arbiter #(
    parameter int TIMEOUT_CYCLES     = 255,
    parameter int STORE_STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        load_request_i,
    input  logic [31:0] load_address_i,
    output logic [31:0] load_data_o,
    output logic        load_done_o,
    output logic        load_error_o,
    input  logic        store_request_i,
    input  logic [31:0] store_address_i,
    input  logic [31:0] store_data_i,
    input  logic [1:0]  store_width_i,
    output logic        store_done_o,
    output logic        store_error_o,
    memory_bus_arbiter_if.master bus,
    output logic [1:0]  state_o
);
    localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TW     = (TW_RAW < 8) ? 8 : TW_RAW;
    localparam int SW_RAW = $clog2(STORE_STARVE_LIMIT + 1);
    localparam int SW     = (SW_RAW < 1) ? 1 : SW_RAW;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD_WAIT  = 2'd1,
        STORE_WAIT = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          flushed_q, flushed_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic          write_q, write_d;
    logic [31:0]   load_data_q, load_data_d;
    logic          load_done_q, load_done_d;
    logic          load_error_q, load_error_d;
    logic          store_done_q, store_done_d;
    logic          store_error_q, store_error_d;

    logic          grant_load, grant_store, load_pending, timeout_hit, finish, kill_load;
    logic [3:0]    store_be;

    always_comb begin
        unique case (store_width_i)
            2'b00:   store_be = 4'b0001 << store_address_i[1:0];
            2'b01:   store_be = store_address_i[1] ? 4'b1100 : 4'b0011;
            default: store_be = 4'b1111;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        starve_d      = starve_q;
        tmo_d         = tmo_q;
        flushed_d     = flushed_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        be_d          = be_q;
        write_d       = write_q;
        load_data_d   = load_data_q;
        load_done_d   = 1'b0;
        load_error_d  = 1'b0;
        store_done_d  = 1'b0;
        store_error_d = 1'b0;
        grant_load    = 1'b0;
        grant_store   = 1'b0;
        finish        = 1'b0;
        load_pending  = load_request_i && !flush_i;
        timeout_hit   = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
        kill_load     = flushed_q || flush_i;

        unique case (state_q)
            IDLE: begin
                if (load_pending && store_request_i) begin
                    if (starve_q == SW'(STORE_STARVE_LIMIT)) grant_store = 1'b1;
                    else                                     grant_load  = 1'b1;
                end else if (load_pending) begin
                    grant_load = 1'b1;
                end else if (store_request_i) begin
                    grant_store = 1'b1;
                end
            end
            LOAD_WAIT, STORE_WAIT: begin
                // Error (bus or timeout) wins over a simultaneous ack.
                if (bus.bus_error_i || timeout_hit) begin
                    finish = 1'b1;
                    if (state_q == LOAD_WAIT) load_error_d  = !kill_load;
                    else                      store_error_d = 1'b1;
                end else if (bus.bus_ack_i) begin
                    finish = 1'b1;
                    if (state_q == LOAD_WAIT) begin
                        load_done_d = !kill_load;
                        if (!kill_load) load_data_d = bus.bus_rdata_i;
                    end else begin
                        store_done_d = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                    if (state_q == LOAD_WAIT && flush_i) flushed_d = 1'b1;
                end
                if (finish) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (grant_load) begin
            state_d   = LOAD_WAIT;
            addr_d    = load_address_i;
            be_d      = 4'b1111;
            write_d   = 1'b0;
            tmo_d     = '0;
            flushed_d = 1'b0;
        end
        if (grant_store) begin
            state_d   = STORE_WAIT;
            addr_d    = store_address_i;
            wdata_d   = store_data_i;
            be_d      = store_be;
            write_d   = 1'b1;
            tmo_d     = '0;
            flushed_d = 1'b0;
        end

        // Counts loads that jumped ahead of a waiting store; saturates at the limit.
        if (!store_request_i || grant_store)                          starve_d = '0;
        else if (grant_load && starve_q != SW'(STORE_STARVE_LIMIT))  starve_d = starve_q + SW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            starve_q      <= '0;
            tmo_q         <= '0;
            flushed_q     <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            be_q          <= '0;
            write_q       <= 1'b0;
            load_data_q   <= '0;
            load_done_q   <= 1'b0;
            load_error_q  <= 1'b0;
            store_done_q  <= 1'b0;
            store_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            starve_q      <= starve_d;
            tmo_q         <= tmo_d;
            flushed_q     <= flushed_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            be_q          <= be_d;
            write_q       <= write_d;
            load_data_q   <= load_data_d;
            load_done_q   <= load_done_d;
            load_error_q  <= load_error_d;
            store_done_q  <= store_done_d;
            store_error_q <= store_error_d;
        end
    end

    assign bus.bus_request_o     = (state_q != IDLE);
    assign bus.bus_write_o       = write_q;
    assign bus.bus_address_o     = addr_q;
    assign bus.bus_wdata_o       = wdata_q;
    assign bus.bus_byte_enable_o = be_q;
    assign load_data_o           = load_data_q;
    assign load_done_o           = load_done_q;
    assign load_error_o          = load_error_q;
    assign store_done_o          = store_done_q;
    assign store_error_o         = store_error_q;
    assign state_o               = state_q;
endmodule
